pipelined_add_sub_nbits: RTL and testbench



---
 rtl/pipelined_add_sub_nbits.sv | 122 ++++++++++++
 tb/tb_pipelined_add_sub_nbits.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_add_sub_nbits.sv
// Pipelined n-bit adder/subtractor with valid/ready on both sides.
// The carry chain is cut into `stages` equal segments. Each segment adds its
// slice of A and B' plus the registered carry of the previous segment.
// Unprocessed operand slices and finished sum slices ride along in skewed
// registers so the full result lines up at the last stage.
module pipelined_add_sub_nbits #(
  parameter int width  = 8,
  parameter int stages = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [width:0]   s_o,
  output logic             ovf_o,
  output logic             zero_o
);

  if (width < 1 || stages < 1 || (width % stages) != 0) begin : g_param_check
    $error("pipelined_add_sub_nbits: width must be >= 1 and divisible by stages >= 1");
  end

  localparam int seg = width / stages;

  logic             en;
  logic [width-1:0] b_op;

  // One enable moves the whole pipe; a held output freezes every stage.
  assign en      = !valid_o | ready_i;
  assign ready_o = en;

  // Subtraction is A + ~B + 1; the +1 enters as the stage-0 carry-in.
  assign b_op = sub_i ? ~b_i : b_i;

  for (genvar k = 0; k < stages; k++) begin : g_stage
    localparam int lo = k * seg;
    localparam int hi = lo + seg;

    logic [width-lo-1:0] a_in;
    logic [width-lo-1:0] b_in;
    logic                c_in;
    logic                v_in;
    logic [seg:0]        seg_sum;
    logic [hi-1:0]       sum_d;
    logic [hi-1:0]       sum_q;
    logic                carry_q;
    logic                valid_q;

    if (k == 0) begin : g_head
      assign a_in  = a_i;
      assign b_in  = b_op;
      assign c_in  = sub_i;
      assign v_in  = valid_i;
      assign sum_d = seg_sum[seg-1:0];
    end else begin : g_body
      assign a_in  = g_stage[k-1].g_fwd.a_q;
      assign b_in  = g_stage[k-1].g_fwd.b_q;
      assign c_in  = g_stage[k-1].carry_q;
      assign v_in  = g_stage[k-1].valid_q;
      assign sum_d = {seg_sum[seg-1:0], g_stage[k-1].sum_q};
    end

    // Bottom slice of whatever operand bits are still outstanding.
    assign seg_sum = {1'b0, a_in[seg-1:0]} + {1'b0, b_in[seg-1:0]} + {{seg{1'b0}}, c_in};

    // Stage register: valid, segment carry and the low sum bits finished so far.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (en) begin
        valid_q <= v_in;
        carry_q <= seg_sum[seg];
        sum_q   <= sum_d;
      end
    end

    if (k < stages - 1) begin : g_fwd
      logic [width-hi-1:0] a_q;
      logic [width-hi-1:0] b_q;

      // Skew the untouched operand slices forward to the next segment.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_in[width-lo-1:seg];
          b_q <= b_in[width-lo-1:seg];
        end
      end
    end else begin : g_tail
      logic msb_cin;
      logic ovf_q;

      // Carry into the MSB recovered from the sum bit and the two operand bits.
      assign msb_cin = seg_sum[seg-1] ^ a_in[seg-1] ^ b_in[seg-1];

      // Signed overflow: carry into the MSB differs from carry out of it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= msb_cin ^ seg_sum[seg];
        end
      end
    end
  end

  assign valid_o = g_stage[stages-1].valid_q;
  assign s_o     = {g_stage[stages-1].carry_q, g_stage[stages-1].sum_q};
  assign ovf_o   = g_stage[stages-1].g_tail.ovf_q;
  // Gated by valid so the flag reads 0 after reset and in bubbles.
  assign zero_o  = valid_o & ~|g_stage[stages-1].sum_q;

endmodule

// File: tb/tb_pipelined_add_sub_nbits.sv
// Scoreboard bench: stimulus pushes expected results, a forked monitor pops them.
module tb_pipelined_add_sub_nbits;

  typedef struct packed {
    logic [32:0] s;
    logic        ovf;
    logic        zero;
    int          cyc;
    logic        chk_lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_i = 1'b0;
  logic       sub_i = 1'b0;
  logic       ready_i = 1'b1;
  logic [7:0] a_i = '0;
  logic [7:0] b_i = '0;
  logic       ready_o, valid_o, ovf_o, zero_o;
  logic [8:0] s_o;

  logic        v32 = 1'b0;
  logic        sub32 = 1'b0;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic        ro32 [3];
  logic        vo32 [3];
  logic        ovf32 [3];
  logic        z32 [3];
  logic [32:0] s32 [3];

  exp_t        q8[$];
  exp_t        qs[3][$];
  logic [31:0] corners [4];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          lat_mode = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_add_sub_nbits #(.width(8), .stages(2)) u_dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .a_i(a_i), .b_i(b_i),
    .sub_i(sub_i), .valid_o(valid_o), .ready_i(ready_i), .s_o(s_o), .ovf_o(ovf_o), .zero_o(zero_o));

  pipelined_add_sub_nbits #(.width(32), .stages(1)) u_w32_s1 (
    .clk(clk), .rst(rst), .valid_i(v32), .ready_o(ro32[0]), .a_i(a32), .b_i(b32),
    .sub_i(sub32), .valid_o(vo32[0]), .ready_i(1'b1), .s_o(s32[0]), .ovf_o(ovf32[0]), .zero_o(z32[0]));

  pipelined_add_sub_nbits #(.width(32), .stages(4)) u_w32_s4 (
    .clk(clk), .rst(rst), .valid_i(v32), .ready_o(ro32[1]), .a_i(a32), .b_i(b32),
    .sub_i(sub32), .valid_o(vo32[1]), .ready_i(1'b1), .s_o(s32[1]), .ovf_o(ovf32[1]), .zero_o(z32[1]));

  pipelined_add_sub_nbits #(.width(32), .stages(8)) u_w32_s8 (
    .clk(clk), .rst(rst), .valid_i(v32), .ready_o(ro32[2]), .a_i(a32), .b_i(b32),
    .sub_i(sub32), .valid_o(vo32[2]), .ready_i(1'b1), .s_o(s32[2]), .ovf_o(ovf32[2]), .zero_o(z32[2]));

  function automatic int stg_of(int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 8;
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(longint a, longint b, bit sub, int w);
    exp_t   e;
    longint m = longint'(1) << w;
    longint low, sa, sb, r;
    e = '0;
    low = sub ? (a - b + m) % m : (a + b) % m;
    e.s = 33'(sub ? ((a >= b) ? m : 0) + low : a + b);
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    r = sub ? sa - sb : sa + sb;
    e.ovf = (r >= m / 2) || (r < -(m / 2));
    e.zero = (low == 0);
    return e;
  endfunction

  function automatic void check(string name, bit ok, string info);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: %s", name, info);
    end
  endfunction

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send8(logic [7:0] a, logic [7:0] b, bit sub, logic [8:0] es, bit eovf, bit ez);
    exp_t e;
    int   t = 0;
    a_i = a; b_i = b; sub_i = sub; valid_i = 1'b1;
    @(negedge clk);
    while (!ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (ready_o) begin
      e = '0;
      e.s = {24'b0, es}; e.ovf = eovf; e.zero = ez; e.cyc = cyc; e.chk_lat = lat_mode;
      q8.push_back(e);
    end else begin
      check("input_accept", 1'b0, $sformatf("ready_o stayed %0b for 100 cycles, want 1", ready_o));
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic sendm(logic [7:0] a, logic [7:0] b, bit sub);
    exp_t e;
    e = model(longint'(a), longint'(b), sub, 8);
    send8(a, b, sub, e.s[8:0], e.ovf, e.zero);
  endtask

  task automatic send32(logic [31:0] a, logic [31:0] b, bit sub);
    exp_t e;
    e = model(longint'(a), longint'(b), sub, 32);
    a32 = a; b32 = b; sub32 = sub; v32 = 1'b1;
    @(negedge clk);
    e.cyc = cyc;
    e.chk_lat = 1'b1;
    for (int i = 0; i < 3; i++) qs[i].push_back(e);
    @(posedge clk);
    #1;
    v32 = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    ready_i = 1'b1;
    while ((q8.size() != 0 || qs[0].size() != 0 || qs[1].size() != 0 || qs[2].size() != 0) && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain", q8.size() == 0 && qs[0].size() == 0 && qs[1].size() == 0 && qs[2].size() == 0,
          $sformatf("pending results %0d/%0d/%0d/%0d, want all 0", q8.size(), qs[0].size(), qs[1].size(), qs[2].size()));
  endtask

  task automatic monitor();
    exp_t       e;
    logic [8:0] hs = '0;
    logic       hovf = 1'b0;
    logic       hz = 1'b0;
    bit         held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
        check("reset_clear", !valid_o && s_o == 9'h0 && !ovf_o && !zero_o && ready_o,
              $sformatf("got valid_o=%0b s_o=%h ovf_o=%0b zero_o=%0b ready_o=%0b, want 0 000 0 0 1",
                        valid_o, s_o, ovf_o, zero_o, ready_o));
        for (int i = 0; i < 3; i++)
          check("reset_clear_w32", !vo32[i] && s32[i] == 33'h0,
                $sformatf("stages=%0d got valid_o=%0b s_o=%h, want 0 0", stg_of(i), vo32[i], s32[i]));
      end else begin
        if (valid_o && !ready_i) begin
          check("stall_ready", !ready_o, $sformatf("got ready_o=%0b during stall, want 0", ready_o));
          if (held)
            check("stall_hold", s_o == hs && ovf_o == hovf && zero_o == hz,
                  $sformatf("got s_o=%h ovf_o=%0b zero_o=%0b, want held %h %0b %0b", s_o, ovf_o, zero_o, hs, hovf, hz));
          hs = s_o; hovf = ovf_o; hz = zero_o; held = 1'b1;
        end else begin
          held = 1'b0;
          if (!valid_o) begin
            check("idle_ready", ready_o, $sformatf("got ready_o=%0b with valid_o=0, want 1", ready_o));
          end else if (q8.size() == 0) begin
            check("unexpected_out", 1'b0, $sformatf("got valid_o=1 s_o=%h, want no result", s_o));
          end else begin
            e = q8.pop_front();
            check("result8", s_o == e.s[8:0] && ovf_o == e.ovf && zero_o == e.zero,
                  $sformatf("got s_o=%h ovf_o=%0b zero_o=%0b, want s_o=%h ovf_o=%0b zero_o=%0b",
                            s_o, ovf_o, zero_o, e.s[8:0], e.ovf, e.zero));
            if (e.chk_lat)
              check("latency8", cyc - e.cyc == 2, $sformatf("got latency %0d, want 2", cyc - e.cyc));
          end
        end
        for (int i = 0; i < 3; i++) begin
          if (vo32[i]) begin
            if (qs[i].size() == 0) begin
              check("unexpected_out_w32", 1'b0, $sformatf("stages=%0d got s_o=%h, want no result", stg_of(i), s32[i]));
            end else begin
              e = qs[i].pop_front();
              check("result_w32", s32[i] == e.s && ovf32[i] == e.ovf && z32[i] == e.zero && ro32[i],
                    $sformatf("stages=%0d got s_o=%h ovf_o=%0b zero_o=%0b ready_o=%0b, want %h %0b %0b 1",
                              stg_of(i), s32[i], ovf32[i], z32[i], ro32[i], e.s, e.ovf, e.zero));
              check("latency_w32", cyc - e.cyc == stg_of(i),
                    $sformatf("stages=%0d got latency %0d, want %0d", stg_of(i), cyc - e.cyc, stg_of(i)));
            end
          end
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'h7FFF_FFFF;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Directed values with hand-computed results.
    lat_mode = 1'b1;
    send8(8'd200, 8'd100, 1'b0, 9'h12C, 1'b0, 1'b0);
    send8(8'd5, 8'd7, 1'b1, 9'h0FE, 1'b0, 1'b0);
    send8(8'd7, 8'd7, 1'b1, 9'h100, 1'b0, 1'b1);
    send8(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, 1'b0);
    send8(8'h80, 8'h01, 1'b1, 9'h17F, 1'b1, 1'b0);
    send8(8'hFF, 8'hFF, 1'b0, 9'h1FE, 1'b0, 1'b0);
    send8(8'h00, 8'h00, 1'b1, 9'h100, 1'b0, 1'b1);
    drain();

    // Backpressure: four adds, downstream stalls three cycles after the first result.
    lat_mode = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++) send8(8'(i), 8'(i), 1'b0, 9'(2 * i), 1'b0, 1'b0);
      end
      begin
        int t = 0;
        @(negedge clk);
        while (!valid_o && t < 50) begin
          @(negedge clk);
          t++;
        end
        if (!valid_o) check("first_valid", 1'b0, "valid_o stayed 0 for 50 cycles, want 1");
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ready_i = 1'b1;
      end
    join
    drain();

    // Reset with two operations in flight: both must vanish.
    lat_mode = 1'b1;
    sendm(8'd10, 8'd20, 1'b0);
    sendm(8'd30, 8'd40, 1'b0);
    rst = 1'b1;
    q8.delete();
    for (int i = 0; i < 3; i++) qs[i].delete();
    #7;
    rst = 1'b0;
    idle(3);
    send8(8'd1, 8'd1, 1'b0, 9'h002, 1'b0, 1'b0);
    drain();

    // Random operands with bubbles and random downstream stalls.
    lat_mode = 1'b0;
    fork
      begin
        for (int k = 0; k < 120; k++) begin
          sendm(8'($urandom), 8'($urandom), 1'($urandom));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
      end
      begin
        for (int k = 0; k < 300; k++) begin
          @(posedge clk);
          #1;
          ready_i = ($urandom_range(0, 3) != 0);
        end
        ready_i = 1'b1;
      end
    join
    drain();

    // 32-bit sweep over stage counts: corners back to back, then random with bubbles.
    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int s = 0; s < 2; s++)
          send32(corners[ia], corners[ib], 1'(s));
    for (int k = 0; k < 60; k++) begin
      send32($urandom, $urandom, 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    drain();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
